// File: rtl/rx_scan_if.sv
// Handshake bundle between rx_scan and its consumers: the move-stack FIFO port
// and the forward port to Tx.
interface rx_scan_if #(
  parameter int unsigned NUM_DIRS = 16
) ();
  localparam int unsigned DIR_W = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;

  logic             move_valid;
  logic             move_ready;
  logic [15:0]      move_data;
  logic             rx_tx_valid;
  logic             rx_tx_ready;
  logic [9:0]       rx_tx_piece;
  logic [DIR_W-1:0] rx_tx_dir;

  modport master (
    output move_valid, move_data, rx_tx_valid, rx_tx_piece, rx_tx_dir,
    input  move_ready, rx_tx_ready
  );

  modport slave (
    input  move_valid, move_data, rx_tx_valid, rx_tx_piece, rx_tx_dir,
    output move_ready, rx_tx_ready
  );
endinterface

// File: rtl/rx_scan.sv
// Per-square receive stage: captures every direction's piece, walks the occupied
// ones, buffers valid moves and forwards sliding pieces. Piece = {color, kind[2:0], square[5:0]}.

module move_checker (
  input  logic [9:0]  piece,
  input  logic [9:0]  dest_piece,
  input  logic        turn,
  input  logic [5:0]  dir,
  output logic        valid,
  output logic        slide_valid,
  output logic [15:0] formatted_move
);
  logic [2:0] kind;
  logic       own;
  logic       dest_ok;

  always_comb begin
    kind           = piece[8:6];
    own            = (piece[9] == turn);
    dest_ok        = (dest_piece == '0) || (dest_piece[9] != turn);
    // Any non-knight piece may arrive along a ray; only bishop/rook/queen keep sliding.
    valid          = own && dest_ok && (kind inside {3'd1, 3'd3, 3'd4, 3'd5, 3'd6});
    slide_valid    = valid && (kind inside {3'd3, 3'd4, 3'd5});
    formatted_move = {piece, dir};
  end
endmodule

module move_checker_knight (
  input  logic [9:0]  piece,
  input  logic [9:0]  dest_piece,
  input  logic        turn,
  input  logic [5:0]  dir,
  output logic        valid,
  output logic [15:0] formatted_move
);
  always_comb begin
    valid          = (piece[9] == turn) && (piece[8:6] == 3'd2) &&
                     ((dest_piece == '0) || (dest_piece[9] != turn));
    formatted_move = {piece, dir};
  end
endmodule

module rx_scan #(
  parameter int unsigned NUM_DIRS     = 16,
  parameter int unsigned KNIGHT_FIRST = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SKIP_EMPTY   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  collect_pieces,
  input  logic [NUM_DIRS*10-1:0] moves,
  input  logic [9:0]            dest_piece,
  input  logic                  turn,
  output logic                  busy,
  output logic                  done,
  rx_scan_if.master             bus
);
  localparam int unsigned DIR_W = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [9:0]          slot [NUM_DIRS];
  logic                turn_q;
  logic [NUM_DIRS-1:0] pending;
  logic [NUM_DIRS-1:0] start_mask;
  logic [NUM_DIRS-1:0] sel_oh;
  logic [DIR_W-1:0]    sel;
  logic [9:0]          sel_piece;
  logic                start;
  logic                is_knight;
  logic                sl_valid, sl_slide, kn_valid;
  logic [15:0]         sl_move, kn_move, wr_data;
  logic                wr_need, fw_need, adv, push, pop;
  logic [15:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_nxt;
  logic                fifo_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign start = collect_pieces && (state == S_IDLE);

  always_comb begin
    start_mask = '1;
    for (int unsigned i = 0; i < NUM_DIRS; i++) begin
      start_mask[i] = (SKIP_EMPTY != 0) ? (moves[i*10 +: 10] != '0) : 1'b1;
    end
  end

  // Scan from the top down so the lowest pending index wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_DIRS; i++) begin
      if (pending[NUM_DIRS-1-i]) sel = DIR_W'(NUM_DIRS - 1 - i);
    end
  end

  assign sel_oh    = NUM_DIRS'(1) << sel;
  assign sel_piece = slot[sel];
  assign is_knight = (32'(sel) >= KNIGHT_FIRST);

  move_checker u_slide (
    .piece          (sel_piece),
    .dest_piece     (dest_piece),
    .turn           (turn_q),
    .dir            (6'(sel)),
    .valid          (sl_valid),
    .slide_valid    (sl_slide),
    .formatted_move (sl_move)
  );

  move_checker_knight u_knight (
    .piece          (sel_piece),
    .dest_piece     (dest_piece),
    .turn           (turn_q),
    .dir            (6'(sel)),
    .valid          (kn_valid),
    .formatted_move (kn_move)
  );

  assign wr_need   = is_knight ? kn_valid : sl_valid;
  assign wr_data   = is_knight ? kn_move : sl_move;
  assign fw_need   = !is_knight && sl_slide;
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign adv       = (state == S_SCAN) && (!wr_need || !fifo_full) &&
                     (!fw_need || bus.rx_tx_ready);
  assign push      = adv && wr_need;
  assign pop       = bus.move_valid && bus.move_ready;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (start_mask != '0) ? S_SCAN : S_DRAIN;
      S_SCAN:  if (adv && ((pending & ~sel_oh) == '0)) state_nxt = S_DRAIN;
      // Looks at the post-pop count so the final pop and DONE are not a cycle apart.
      S_DRAIN: if (count_nxt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    bus.rx_tx_valid = (state == S_SCAN) && fw_need;
  end

  assign bus.rx_tx_piece = sel_piece;
  assign bus.rx_tx_dir   = sel;
  assign bus.move_valid  = (count != '0);
  assign bus.move_data   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_DIRS; i++) slot[i] <= '0;
      turn_q <= 1'b0;
    end else if (start) begin
      for (int unsigned i = 0; i < NUM_DIRS; i++) slot[i] <= moves[i*10 +: 10];
      turn_q <= turn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pending <= '0;
    else if (start) pending <= start_mask;
    else if (adv)   pending <= pending & ~sel_oh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_rx_scan.sv
// Bench for rx_scan: table of scan scenarios, hand-written stall/reset/ignore
// sequences and randomized scans, all checked against a move/forward reference model.
module tb_rx_scan;
  localparam int ND = 16;
  localparam int KF = 8;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            collect_pieces;
  logic [ND*10-1:0] moves;
  logic [9:0]      dest_piece;
  logic            turn;
  logic            busy, done;

  rx_scan_if #(.NUM_DIRS(ND)) bus ();

  rx_scan #(.NUM_DIRS(ND), .KNIGHT_FIRST(KF), .FIFO_DEPTH(FD), .SKIP_EMPTY(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .collect_pieces (collect_pieces),
    .moves          (moves),
    .dest_piece     (dest_piece),
    .turn           (turn),
    .busy           (busy),
    .done           (done),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int fw_cnt = 0;
  logic [15:0] exp_mv[$];
  logic [13:0] exp_fw[$];
  bit   rnd_mode = 1'b0;
  logic mr_force = 1'b1;
  logic fr_force = 1'b1;

  typedef struct {
    logic [ND*10-1:0] mv;
    bit               tn;
    logic [9:0]       dst;
    int               n_push;
    int               n_fw;
    int               done_cyc;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] pc(input bit color, input int kind, input int sq);
    return {color, 3'(kind), 6'(sq)};
  endfunction

  function automatic logic [ND*10-1:0] put(input logic [ND*10-1:0] m, input int i,
                                           input logic [9:0] p);
    logic [ND*10-1:0] r;
    r = m;
    r[i*10 +: 10] = p;
    return r;
  endfunction

  // Reference: occupied directions in index order; validity from ownership,
  // destination and piece kind vs. direction class.
  task automatic model(input logic [ND*10-1:0] mv, input bit tn, input logic [9:0] dst);
    logic [9:0] p;
    int  k;
    bit  ok, dok;
    for (int i = 0; i < ND; i++) begin
      p = mv[i*10 +: 10];
      if (p == 10'd0) continue;
      k   = int'(p[8:6]);
      dok = (dst == 10'd0) || (dst[9] != tn);
      if (i >= KF) ok = (p[9] == tn) && dok && (k == 2);
      else         ok = (p[9] == tn) && dok && (k inside {1, 3, 4, 5, 6});
      if (ok) exp_mv.push_back({p, 6'(i)});
      if (ok && i < KF && (k inside {3, 4, 5})) exp_fw.push_back({p, 4'(i)});
    end
  endtask

  task automatic start_scan(input bit sync, input logic [ND*10-1:0] mv, input bit tn,
                            input logic [9:0] dst);
    if (sync) @(negedge clk);
    moves = mv; turn = tn; dest_piece = dst; collect_pieces = 1'b1;
    pop_cnt = 0; fw_cnt = 0;
    model(mv, tn, dst);
    @(posedge clk);
    #1 collect_pieces = 1'b0;
  endtask

  task automatic wait_done(input int from, input int exp_cyc, input string name);
    int got = -1;
    bit gap = 1'b0;
    for (int c = from + 1; c <= from + 400; c++) begin
      @(negedge clk);
      if (done) begin got = c; break; end
      if (!busy) gap = 1'b1;
    end
    if (exp_cyc >= 0) chk({name, "_done_cyc"}, got, exp_cyc);
    else              chk({name, "_done_seen"}, 32'(got > 0), 1);
    chk({name, "_busy_during"}, 32'(gap), 0);
    @(negedge clk);
    chk({name, "_idle_after"}, {busy, done}, 2'b00);
    chk({name, "_mv_left"}, exp_mv.size(), 0);
    chk({name, "_fw_left"}, exp_fw.size(), 0);
  endtask

  // Ready drivers: change just after the rising edge.
  initial begin
    bus.move_ready  = 1'b1;
    bus.rx_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        bus.move_ready  = ($urandom_range(0, 3) != 0);
        bus.rx_tx_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.move_ready  = mr_force;
        bus.rx_tx_ready = fr_force;
      end
    end
  end

  // Handshake monitor: sampled mid-cycle, the transfer happens at the next edge.
  initial begin
    logic       pfv = 1'b0, pfr = 1'b0;
    logic [13:0] pfd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.move_valid && bus.move_ready) begin
          pop_cnt++;
          chk("mv_expected", 32'(exp_mv.size() != 0), 1);
          if (exp_mv.size() != 0) chk("mv_data", bus.move_data, exp_mv.pop_front());
        end
        if (bus.rx_tx_valid && bus.rx_tx_ready) begin
          fw_cnt++;
          chk("fw_expected", 32'(exp_fw.size() != 0), 1);
          if (exp_fw.size() != 0) chk("fw_data", {bus.rx_tx_piece, bus.rx_tx_dir}, exp_fw.pop_front());
        end
        if (pfv && !pfr) chk("fw_hold", {bus.rx_tx_valid, bus.rx_tx_piece, bus.rx_tx_dir}, {1'b1, pfd});
        pfv = bus.rx_tx_valid;
        pfr = bus.rx_tx_ready;
        pfd = {bus.rx_tx_piece, bus.rx_tx_dir};
      end else begin
        pfv = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [ND*10-1:0] m;
    logic [ND*10-1:0] six;
    int n_push_exp, n_fw_exp;

    tbl[0] = '{'0, 1'b0, 10'd0, 0, 0, 2};
    m = put(put(put('0, 0, pc(0, 4, 10)), 3, pc(0, 1, 20)), 9, pc(0, 2, 33));
    tbl[1] = '{m, 1'b0, 10'd0, 3, 1, 5};
    tbl[2] = '{put('0, 1, pc(1, 4, 7)), 1'b0, 10'd0, 0, 0, 3};
    m = put(put(put('0, 2, pc(0, 2, 1)), 8, pc(0, 3, 2)), 12, pc(0, 2, 3));
    tbl[3] = '{m, 1'b0, 10'd0, 1, 0, 5};
    tbl[4] = '{put(put('0, 0, pc(0, 5, 1)), 5, pc(0, 6, 2)), 1'b0, pc(0, 6, 44), 0, 0, 4};
    m = put(put(put('0, 4, pc(1, 3, 5)), 15, pc(1, 2, 6)), 7, pc(0, 4, 7));
    tbl[5] = '{m, 1'b1, pc(0, 1, 9), 2, 1, 5};
    six = '0;
    for (int i = 0; i < 6; i++) six = put(six, i, pc(0, 1, i + 1));

    rst = 1'b0; collect_pieces = 1'b0; moves = '0; turn = 1'b0; dest_piece = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mvalid", bus.move_valid, 0);
    chk("rst_fvalid", bus.rx_tx_valid, 0);
    chk("rst_mdata", bus.move_data, 0);
    chk("rst_fpiece", bus.rx_tx_piece, 0);
    chk("rst_fdir", bus.rx_tx_dir, 0);
    rst = 1'b1;

    // Table scenarios, issued back-to-back in the first idle cycle after DONE.
    for (int v = 0; v < 6; v++) begin
      start_scan(v == 0, tbl[v].mv, tbl[v].tn, tbl[v].dst);
      wait_done(0, tbl[v].done_cyc, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d_pushes", v), pop_cnt, tbl[v].n_push);
      chk($sformatf("tbl%0d_fwds", v), fw_cnt, tbl[v].n_fw);
    end

    // FIFO full stall.
    mr_force = 1'b0;
    start_scan(1, six, 1'b0, 10'd0);
    for (int c = 1; c <= 8; c++) @(negedge clk);
    chk("stall_mvalid", bus.move_valid, 1);
    chk("stall_busy", busy, 1);
    chk("stall_sel", bus.rx_tx_dir, 4);
    chk("stall_done", done, 0);
    mr_force = 1'b1;
    wait_done(8, -1, "stall");
    chk("stall_pushes", pop_cnt, 6);

    // Forward back-pressure.
    fr_force = 1'b0;
    start_scan(1, put('0, 2, pc(0, 4, 12)), 1'b0, 10'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("fwh_valid", bus.rx_tx_valid, 1);
      chk("fwh_dir", bus.rx_tx_dir, 2);
      chk("fwh_piece", bus.rx_tx_piece, pc(0, 4, 12));
      chk("fwh_nopush", bus.move_valid, 0);
    end
    fr_force = 1'b1;
    @(negedge clk);
    chk("fwr_handshake", {bus.rx_tx_valid, bus.rx_tx_ready, bus.move_valid}, 3'b110);
    @(negedge clk);
    chk("fwr_pushed", {bus.move_valid, bus.rx_tx_valid}, 2'b10);
    wait_done(7, 8, "fwstall");
    chk("fwstall_fwds", fw_cnt, 1);

    // Start while busy is ignored.
    start_scan(1, tbl[1].mv, 1'b0, 10'd0);
    @(negedge clk);
    @(negedge clk);
    moves = put(put('0, 1, pc(1, 1, 5)), 11, pc(1, 2, 6));
    turn = 1'b1;
    collect_pieces = 1'b1;
    @(posedge clk);
    #1 collect_pieces = 1'b0;
    wait_done(2, 5, "ignore");
    chk("ignore_pushes", pop_cnt, 3);
    chk("ignore_fwds", fw_cnt, 1);

    // Reset during SCAN with two buffered moves.
    mr_force = 1'b0;
    start_scan(1, six, 1'b0, 10'd0);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    chk("prerst_mvalid", {bus.move_valid, busy}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state", {busy, done, bus.move_valid, bus.rx_tx_valid}, 4'b0000);
    @(negedge clk);
    chk("midrst_next", {busy, done, bus.move_valid, bus.rx_tx_valid}, 4'b0000);
    rst = 1'b1;
    exp_mv.delete();
    exp_fw.delete();
    mr_force = 1'b1;
    start_scan(1, tbl[1].mv, 1'b0, 10'd0);
    wait_done(0, 5, "post_rst");
    chk("post_rst_pushes", pop_cnt, 3);
    chk("post_rst_fwds", fw_cnt, 1);

    // Randomized scans with random back-pressure.
    rnd_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      m = '0;
      for (int i = 0; i < ND; i++)
        if ($urandom_range(0, 1) != 0) m = put(m, i, 10'($urandom));
      start_scan(1, m, 1'($urandom), ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom));
      n_push_exp = exp_mv.size();
      n_fw_exp   = exp_fw.size();
      wait_done(0, -1, "rand");
      chk("rand_pushes", pop_cnt, n_push_exp);
      chk("rand_fwds", fw_cnt, n_fw_exp);
    end
    rnd_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_scan.md
# rx_scan

Parametrised, self-sequencing successor to the per-square receive stage of the move generator. On `collect_pieces` it captures the pieces from every surrounding direction and walks the occupied directions on its own, one per cycle. Each captured piece goes to `move_checker` (sliding directions) or `move_checker_knight` (knight directions). Valid moves are buffered in a small FIFO with a ready/valid port to the move stack. Sliding pieces are forwarded to Tx under a ready/valid handshake.

## Interface
- `NUM_DIRS`, 16, number of direction slots (≥2).
- `KNIGHT_FIRST`, 8, first direction index handled as a knight direction; indices below it are sliding.
- `FIFO_DEPTH`, 4, move FIFO entries (≥1).
- `SKIP_EMPTY`, 1, 1: directions holding an all-zero piece are skipped; 0: every direction is visited.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `collect_pieces`  in  1  start pulse; honoured only in IDLE.
- `moves`  in  NUM_DIRS*10  slot i = `moves[i*10+9:i*10]`.
- `dest_piece`  in  10  piece on this square; held stable while `busy`.
- `turn`  in  1  side to move; latched with `collect_pieces`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a scan completes.
- `move_valid` / `move_ready` / `move_data`  out/in/out  1/1/16  FIFO head to stack.
- `rx_tx_valid` / `rx_tx_ready`  out/in  1/1  forward handshake to Tx.
- `rx_tx_piece`  out  10  forwarded piece.
- `rx_tx_dir`  out  clog2(NUM_DIRS)  direction index of the forwarded piece.

## Operation
- Slot registers: on accepted start, load all slots and `turn`. Pending mask bit i = (slot i != 0) when SKIP_EMPTY=1; otherwise all ones.
- `sel` = lowest set pending bit. The checker is picked by `sel >= KNIGHT_FIRST`.
- `wr_need` = checker valid. `fw_need` = sliding direction AND `slide_valid`. Knight directions never forward.
- `adv` = SCAN AND (!wr_need OR fifo count < FIFO_DEPTH) AND (!fw_need OR `rx_tx_ready`).
- On `adv`: push `formatted_move` if `wr_need`, complete the forward if `fw_need`, and clear pending bit `sel`. Push and forward happen in the same cycle, so nothing is ever duplicated.
- `rx_tx_valid` = SCAN AND `fw_need`, combinational. `rx_tx_piece` and `rx_tx_dir` show the selected slot. Once raised, `rx_tx_valid` stays high until accepted, because `sel` does not change while stalled.
- FSM:
  - IDLE → SCAN on start if the mask is nonzero; → DRAIN if the mask is zero.
  - SCAN → DRAIN when `adv` clears the last pending bit.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → IDLE unconditionally. `done` = (state == DONE).
- FIFO: show-ahead. `move_valid` = count != 0. Pop on `move_valid && move_ready`. Count width is clog2(FIFO_DEPTH+1). Fullness uses the registered count, so a pop in the same cycle does not let a full FIFO accept a push. Pointers wrap modulo FIFO_DEPTH.
- `collect_pieces` while busy is ignored: slots, `turn` and mask stay unchanged.

## Timing
- Reset values: state IDLE, FIFO empty, slots/mask/`turn` 0; `busy`, `done`, `move_valid`, `rx_tx_valid` 0; `move_data`, `rx_tx_piece`, `rx_tx_dir` 0.
- Reset asserted mid-operation aborts immediately. The FIFO is flushed and no further pushes or forwards occur.
- Start sampled at edge 0. The first direction is evaluated in cycle 1.
- Unstalled, each visited direction costs 1 cycle. Scan with N visited directions and `move_ready` held high: `done` is high in cycle N+2 and `busy` is low from cycle N+3.
- Empty mask: DRAIN in cycle 1, DONE in cycle 2.
- A pushed move is visible on `move_data` the cycle after the push.
- Back-to-back scans: a start is accepted in the first cycle after DONE.

## Test plan
- All-zero `moves`, SKIP_EMPTY=1, pulse start → `busy` 1 for cycles 1–2, `done` in cycle 2, no `move_valid` and no `rx_tx_valid` ever.
- Slots 0, 3 and 9 hold pieces that the checker models flag as valid (slot 0 also slide-valid), `move_ready`=`rx_tx_ready`=1 → 3 pushes in cycles 1–3 in order 0, 3, 9. One forward with `rx_tx_dir`=0. `done` in cycle 5.
- 6 valid directions, FIFO_DEPTH=4, `move_ready`=0 → 4 entries, then a stall with `sel` fixed and `busy` high. Raising `move_ready` → remaining 2 pushed, all 6 moves popped in direction order, then `done`.
- Slide-valid slot 2 with `rx_tx_ready`=0 for 5 cycles → `rx_tx_valid` held with stable piece/dir, no push or advance. The forward and the push occur in the cycle `rx_tx_ready` rises.
- Second `collect_pieces` with different `moves` in cycle 2 of a scan → ignored; outputs match the first capture only.
- `rst` low during SCAN with 2 FIFO entries → next cycle IDLE, `move_valid` 0, `busy` 0. A new scan afterwards behaves as from power-up.
